// File: rtl/cdb_pkg.sv
// Shared CDB types: result packet layout and the functional-unit enum used as requester index.
package cdb_pkg;
  localparam int CDB_XLEN    = 32;
  localparam int CDB_TAG_LEN = 6;
  localparam int CDB_NUM_FU  = 4;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_MULT = 2'd1,
    FU_BTU  = 2'd2,
    FU_LSU  = 2'd3
  } fu_e;

  typedef struct packed {
    logic [CDB_TAG_LEN-1:0] rob_tag;
    logic [CDB_XLEN-1:0]    value;
  } CDB_PACKET;
endpackage

// File: rtl/cdb_fu_buffer.sv
// Per-FU result FIFO: push/pop/flush with natural-wrap pointers and an explicit occupancy count.
module cdb_fu_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 38
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [W-1:0]           i_din,
  output logic [W-1:0]           o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
    end
  end

  // Storage carries no reset; the count alone says which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full  = (r_count == (AW+1)'(DEPTH));
endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: per-FU result FIFOs drained one head per cycle by a
// round-robin pick into a registered broadcast.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU    = CDB_NUM_FU,
  parameter int BUF_DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          squash,
  input  logic [NUM_FU-1:0]             fu_valid,
  input  logic [NUM_FU*CDB_TAG_LEN-1:0] fu_rob_tag,
  input  logic [NUM_FU*CDB_XLEN-1:0]    fu_value,
  output logic [NUM_FU-1:0]             fu_ready,
  output logic                          cdb_valid,
  output logic [CDB_TAG_LEN-1:0]        cdb_rob_tag,
  output logic [CDB_XLEN-1:0]           cdb_value,
  output logic [$clog2(NUM_FU)-1:0]     cdb_src
);
  localparam int SW = $clog2(NUM_FU);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int PW = $bits(CDB_PACKET);

  logic [PW-1:0]       w_head [NUM_FU];
  logic [CW-1:0]       w_count [NUM_FU];
  logic [NUM_FU-1:0]   w_full, w_req, w_push, w_pop;
  logic [2*NUM_FU-1:0] w_req2;
  logic [NUM_FU-1:0]   w_rot;
  logic [SW-1:0]       w_off, w_win, w_rr_nxt;
  logic [SW:0]         w_sum;
  logic                w_any;
  CDB_PACKET           w_win_pkt;

  logic [SW-1:0]          r_rr_ptr;
  logic                   r_cdb_valid;
  logic [CDB_TAG_LEN-1:0] r_cdb_tag;
  logic [CDB_XLEN-1:0]    r_cdb_value;
  logic [SW-1:0]          r_cdb_src;

  for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_fu
    CDB_PACKET w_din;
    assign w_din = '{rob_tag: fu_rob_tag[gi*CDB_TAG_LEN +: CDB_TAG_LEN],
                     value:   fu_value[gi*CDB_XLEN +: CDB_XLEN]};
    assign fu_ready[gi] = !w_full[gi];
    assign w_push[gi]   = fu_valid[gi] && !w_full[gi];
    assign w_req[gi]    = (w_count[gi] != '0);
    assign w_pop[gi]    = w_any && (w_win == SW'(gi));

    cdb_fu_buffer #(.DEPTH(BUF_DEPTH), .W(PW)) u_buf (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_flush (squash),
      .i_push  (w_push[gi]),
      .i_pop   (w_pop[gi]),
      .i_din   (w_din),
      .o_head  (w_head[gi]),
      .o_count (w_count[gi]),
      .o_full  (w_full[gi])
    );
  end

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_req2 = {w_req, w_req};
    w_rot  = w_req2[r_rr_ptr +: NUM_FU];
    w_off  = '0;
    for (int k = NUM_FU - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = SW'(k);
    end
    w_sum = {1'b0, r_rr_ptr} + {1'b0, w_off};
    if (w_sum >= (SW+1)'(NUM_FU)) w_sum = w_sum - (SW+1)'(NUM_FU);
    w_win    = w_sum[SW-1:0];
    w_any    = |w_req;
    w_rr_nxt = (w_win == SW'(NUM_FU - 1)) ? '0 : w_win + SW'(1);
  end

  assign w_win_pkt = CDB_PACKET'(w_head[w_win]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_value <= '0;
      r_cdb_src   <= '0;
    end else if (squash) begin
      r_cdb_valid <= 1'b0;
    end else if (w_any) begin
      r_cdb_valid <= 1'b1;
      r_cdb_tag   <= w_win_pkt.rob_tag;
      r_cdb_value <= w_win_pkt.value;
      r_cdb_src   <= w_win;
      r_rr_ptr    <= w_rr_nxt;
    end else begin
      r_cdb_valid <= 1'b0;
    end
  end

  assign cdb_valid   = r_cdb_valid;
  assign cdb_rob_tag = r_cdb_tag;
  assign cdb_value   = r_cdb_value;
  assign cdb_src     = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: stimulus records expected broadcasts per FU,
// a negedge monitor pops and compares every broadcast the bus presents.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  typedef logic [CDB_TAG_LEN+CDB_XLEN-1:0] ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        squash = 1'b0;
  logic [3:0]  fu_valid = '0;
  logic [23:0] fu_rob_tag = '0;
  logic [127:0] fu_value = '0;
  logic [3:0]  fu_ready;
  logic        cdb_valid;
  logic [5:0]  cdb_rob_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t sb0[$], sb1[$], sb2[$], sb3[$];
  int   q_src[$];

  cdb_arbiter #(.NUM_FU(4), .BUF_DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .squash      (squash),
    .fu_valid    (fu_valid),
    .fu_rob_tag  (fu_rob_tag),
    .fu_value    (fu_value),
    .fu_ready    (fu_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_tag (cdb_rob_tag),
    .cdb_value   (cdb_value),
    .cdb_src     (cdb_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int fu, input logic [5:0] t, input logic [31:0] v);
    case (fu)
      0: sb0.push_back({t, v});
      1: sb1.push_back({t, v});
      2: sb2.push_back({t, v});
      default: sb3.push_back({t, v});
    endcase
  endtask

  task automatic pop_exp(input int fu, output bit ok, output ent_t e);
    ok = 1'b0;
    e  = '0;
    case (fu)
      0: if (sb0.size() > 0) begin e = sb0.pop_front(); ok = 1'b1; end
      1: if (sb1.size() > 0) begin e = sb1.pop_front(); ok = 1'b1; end
      2: if (sb2.size() > 0) begin e = sb2.pop_front(); ok = 1'b1; end
      default: if (sb3.size() > 0) begin e = sb3.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic drive(input int fu, input logic [5:0] t, input logic [31:0] v);
    fu_valid[fu]          = 1'b1;
    fu_rob_tag[fu*6 +: 6] = t;
    fu_value[fu*32 +: 32] = v;
  endtask

  // Called at a negedge after driving: log what the coming edge accepts, then advance.
  task automatic cycle(input bit rec);
    for (int i = 0; i < 4; i++) begin
      if (rec && fu_valid[i] && fu_ready[i] && !squash && !reset)
        push_exp(i, fu_rob_tag[i*6 +: 6], fu_value[i*32 +: 32]);
    end
    @(negedge clk);
    fu_valid = '0;
    squash   = 1'b0;
  endtask

  // Monitor
  bit   m_ok;
  ent_t m_e;
  always @(negedge clk) begin
    if (!reset && cdb_valid) begin
      if (q_src.size() > 0) chk("src_order", 64'(cdb_src), 64'(q_src.pop_front()));
      pop_exp(int'(cdb_src), m_ok, m_e);
      if (!m_ok) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_broadcast: got src=%0d tag=%0h, expected no broadcast", cdb_src, cdb_rob_tag);
      end else begin
        chk("cdb_tag", 64'(cdb_rob_tag), 64'(m_e[37:32]));
        chk("cdb_value", 64'(cdb_value), 64'(m_e[31:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  logic [3:0] acc;
  int m;

  initial begin
    // 1. reset and idle
    repeat (3) @(posedge clk);
    chk("reset_valid_held", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_valid", 64'(cdb_valid), 64'd0);
    chk("reset_ready", 64'(fu_ready), 64'hF);
    chk("reset_tag", 64'(cdb_rob_tag), 64'd0);
    chk("reset_value", 64'(cdb_value), 64'd0);
    repeat (4) @(negedge clk);

    // 2. single ALU result, two-edge latency
    drive(int'(FU_ALU), 6'd5, 32'hDEAD_BEEF);
    q_src.push_back(int'(FU_ALU));
    cycle(1);
    chk("no_bypass_valid", 64'(cdb_valid), 64'd0);
    @(negedge clk);
    chk("lat_valid", 64'(cdb_valid), 64'd1);
    @(negedge clk);
    chk("lat_valid_drop", 64'(cdb_valid), 64'd0);

    // 3. all four at once from rr_ptr=0
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(i, 6'(i + 1), 32'hA000_0000 + 32'(i));
      q_src.push_back(i);
    end
    cycle(1);
    repeat (6) @(negedge clk);

    // 4. MULT streams while the others hold it off; FIFO fills
    m = 0;
    for (int i = 0; i < 4; i++) q_src.push_back(i);
    for (int c = 0; c < 16; c++) begin
      if (c == 0) begin
        drive(0, 6'd20, 32'h2000_0000);
        drive(2, 6'd22, 32'h2200_0000);
        drive(3, 6'd23, 32'h2300_0000);
      end
      if (m < 6) drive(1, 6'(10 + m), 32'h1000 + 32'(m));
      if (c == 2) chk("mult_full_ready", 64'(fu_ready[1]), 64'd0);
      if (fu_valid[1] && fu_ready[1]) m++;
      cycle(1);
    end
    chk("mult_all_accepted", 64'(m), 64'd6);
    repeat (4) @(negedge clk);

    // 5. squash with three buffered and a MULT push on the same edge
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) drive(i, 6'(40 + i), 32'h4000_0000 + 32'(i));
    push_exp(0, 6'd40, 32'h4000_0000);
    q_src.push_back(0);
    cycle(0);
    @(negedge clk);
    chk("pre_squash_valid", 64'(cdb_valid), 64'd1);
    drive(int'(FU_MULT), 6'd50, 32'h5000_0000);
    squash = 1'b1;
    cycle(0);
    chk("squash_valid", 64'(cdb_valid), 64'd0);
    chk("squash_ready", 64'(fu_ready), 64'hF);
    repeat (5) @(negedge clk);
    chk("squash_idle_valid", 64'(cdb_valid), 64'd0);

    // 6. async reset while a broadcast is on the bus
    drive(int'(FU_BTU), 6'd9, 32'h0000_1234);
    cycle(1);
    @(negedge clk);
    #1;
    chk("pre_areset_valid", 64'(cdb_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("areset_valid", 64'(cdb_valid), 64'd0);
    chk("areset_tag", 64'(cdb_rob_tag), 64'd0);
    chk("areset_value", 64'(cdb_value), 64'd0);
    chk("areset_src", 64'(cdb_src), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // random traffic, FUs hold data until accepted
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!fu_valid[i] && ($urandom_range(0, 1) == 1)) begin
          fu_valid[i]          = 1'b1;
          fu_rob_tag[i*6 +: 6] = 6'($urandom);
          fu_value[i*32 +: 32] = $urandom;
        end
      end
      acc = fu_valid & fu_ready;
      for (int i = 0; i < 4; i++)
        if (acc[i]) push_exp(i, fu_rob_tag[i*6 +: 6], fu_value[i*32 +: 32]);
      @(negedge clk);
      fu_valid = fu_valid & ~acc;
    end
    fu_valid = '0;
    repeat (12) @(negedge clk);
    chk("drain_empty", 64'(sb0.size() + sb1.size() + sb2.size() + sb3.size() + q_src.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
